// File: rtl/jpeg_raster_pkg.sv
// Shared definitions for the MCU-to-raster converter.
// Holds the MCU edge sizes, the strip-bank and read-FSM state encodings,
// and a constant clog2 used to size the strip RAM address.
package jpeg_raster_pkg;

   localparam int MCU_411 = 16;
   localparam int MCU_444 = 8;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FULL     = 2'd1,
      BANK_DRAINING = 2'd2
   } bank_st_e;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_DRAIN = 2'd1,
      RD_DONE  = 2'd2
   } rd_st_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/jpeg_strip_ram.sv
// Simple dual-port strip buffer: one write port, one read port with a
// registered output (1-cycle read latency).
// Ports: clk; we/wa/wd write port; re/ra read request; rd read data.
module jpeg_strip_ram #(
   parameter int DW = 24,
   parameter int AW = 15
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [DW-1:0] wd,
   input  logic          re,
   input  logic [AW-1:0] ra,
   output logic [DW-1:0] rd
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rd <= mem[ra];
   end

endmodule

// File: rtl/jpeg_mcu2raster.sv
// MCU-order to raster-order converter with a ping-pong strip buffer.
// One bank per MCU row; bank = in_y_mcu[0]. A strip is written while the
// other bank drains in raster order through a 2-entry output FIFO.
// Ports: clk/rst (sync, active-high); cfg_* latched on accepted in_begin;
// in_* MCU pixel stream with in_we/in_next handshake; out_* raster stream
// with out_valid/out_ready handshake and sof/eol/eof markers; busy while a
// frame is in progress.
//
// Read FSM:
//   state    | meaning
//   RD_IDLE  | wait for the expected bank to become FULL
//   RD_DRAIN | scan lines x columns of the strip, one RAM read per cycle
//   RD_DONE  | release the bank; end frame or toggle expected bank
module jpeg_mcu2raster
   import jpeg_raster_pkg::*;
#(
   parameter int PIX_W     = 8,
   parameter int MAX_WIDTH = 1024,
   parameter int XW        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_411,
   input  logic [XW-1:0]    cfg_width,
   input  logic [XW-1:0]    cfg_height,
   input  logic [12:0]      cfg_mcu_w,
   input  logic             in_we,
   output logic             in_next,
   input  logic             in_begin,
   input  logic             in_end,
   input  logic [PIX_W-1:0] in_r,
   input  logic [PIX_W-1:0] in_g,
   input  logic [PIX_W-1:0] in_b,
   input  logic [7:0]       in_adr,
   input  logic [12:0]      in_x_mcu,
   input  logic [12:0]      in_y_mcu,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_r,
   output logic [PIX_W-1:0] out_g,
   output logic [PIX_W-1:0] out_b,
   output logic [XW-1:0]    out_x,
   output logic [XW-1:0]    out_y,
   output logic             out_sof,
   output logic             out_eol,
   output logic             out_eof,
   output logic             busy
);

   localparam int CW = clog2(MAX_WIDTH);
   localparam int AW = 5 + CW;
   localparam int DW = 3 * PIX_W;
   localparam logic [4:0] M16 = 5'(MCU_411);
   localparam logic [4:0] M8  = 5'(MCU_444);

   logic          c411;
   logic [XW-1:0] cw, ch;
   logic [12:0]   cmw;
   logic          busy_q;
   bank_st_e      bank_st [2];
   logic          last_q [2];
   logic [16:0]   sy [2];

   // Write side. The pixel carrying in_begin uses the live cfg_* inputs,
   // since the latched copy only updates at the end of that cycle.
   logic          take_cfg, e411, wbank, acc, frame_on, ram_we, last_adr, mark;
   logic [XW-1:0] ew;
   logic [12:0]   emw;
   logic [16:0]   col, wsy;
   logic [3:0]    wline;
   logic [AW-1:0] wa;

   always_comb begin
      take_cfg = in_begin && !busy_q;
      e411     = take_cfg ? cfg_411   : c411;
      ew       = take_cfg ? cfg_width : cw;
      emw      = take_cfg ? cfg_mcu_w : cmw;
      wbank    = in_y_mcu[0];
      if (e411) begin
         col      = {in_x_mcu, in_adr[3:0]};
         wline    = in_adr[7:4];
         wsy      = {in_y_mcu, 4'b0};
         last_adr = (in_adr == 8'hFF);
      end else begin
         col      = {1'b0, in_x_mcu, in_adr[2:0]};
         wline    = {1'b0, in_adr[5:3]};
         wsy      = {1'b0, in_y_mcu, 3'b0};
         last_adr = (in_adr[5:0] == 6'h3F);
      end
      in_next  = (bank_st[wbank] == BANK_EMPTY) && !(in_begin && busy_q);
      frame_on = busy_q || take_cfg;
      acc      = in_we && in_next && frame_on;
      mark     = acc && ((last_adr && (in_x_mcu == emw - 13'd1)) || in_end);
      // Cropped columns are not stored but still count toward completion.
      ram_we   = acc && (col < {1'b0, ew});
      wa       = {wbank, wline, col[CW-1:0]};
   end

   // Read side
   rd_st_e        st, st_nx;
   logic          exp_bank, start, issue, release_b, last_rd, space, pop, pend;
   logic [XW-1:0] rx, ry, p_x, p_y;
   logic [3:0]    rline;
   logic [4:0]    rlines, m_sz;
   logic [17:0]   rem;
   logic [1:0]    cnt;
   logic          p_sof, p_eol, p_eof;
   logic [DW-1:0] ram_rd;
   logic          wp, rp;
   logic [DW-1:0] f_rgb [2];
   logic [XW-1:0] f_x [2];
   logic [XW-1:0] f_y [2];
   logic [2:0]    f_flg [2];

   always_comb begin
      pop     = out_valid && out_ready;
      // Issue only if the FIFO can hold everything already buffered or in
      // flight plus this read; counting the same-cycle pop keeps 1 pixel/clk.
      space   = ({1'b0, cnt} + {2'b0, pend}) <= (3'd1 + {2'b0, pop});
      last_rd = (rx == cw - XW'(1)) && ({1'b0, rline} == rlines - 5'd1);
      ry      = sy[exp_bank][XW-1:0] + XW'(rline);
      rem     = {{(18-XW){1'b0}}, ch} - {1'b0, sy[exp_bank]};
      m_sz    = c411 ? M16 : M8;
   end

   always_ff @(posedge clk) begin
      if (rst) st <= RD_IDLE;
      else     st <= st_nx;
   end

   always_comb begin
      st_nx = st;
      case (st)
         RD_IDLE:  if (bank_st[exp_bank] == BANK_FULL) st_nx = RD_DRAIN;
         RD_DRAIN: if (issue && last_rd) st_nx = RD_DONE;
         RD_DONE:  st_nx = RD_IDLE;
         default:  st_nx = RD_IDLE;
      endcase
   end

   always_comb begin
      start     = 1'b0;
      issue     = 1'b0;
      release_b = 1'b0;
      case (st)
         RD_IDLE:  start     = (bank_st[exp_bank] == BANK_FULL);
         RD_DRAIN: issue     = space;
         RD_DONE:  release_b = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         c411       <= 1'b0;
         cw         <= '0;
         ch         <= '0;
         cmw        <= '0;
         busy_q     <= 1'b0;
         bank_st[0] <= BANK_EMPTY;
         bank_st[1] <= BANK_EMPTY;
         last_q[0]  <= 1'b0;
         last_q[1]  <= 1'b0;
         sy[0]      <= '0;
         sy[1]      <= '0;
         exp_bank   <= 1'b0;
         rx         <= '0;
         rline      <= '0;
         rlines     <= '0;
         pend       <= 1'b0;
         p_x        <= '0;
         p_y        <= '0;
         p_sof      <= 1'b0;
         p_eol      <= 1'b0;
         p_eof      <= 1'b0;
         cnt        <= '0;
         wp         <= 1'b0;
         rp         <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            f_rgb[i] <= '0;
            f_x[i]   <= '0;
            f_y[i]   <= '0;
            f_flg[i] <= '0;
         end
      end else begin
         if (acc && take_cfg) begin
            busy_q <= 1'b1;
            c411   <= cfg_411;
            cw     <= cfg_width;
            ch     <= cfg_height;
            cmw    <= cfg_mcu_w;
         end
         if (start) begin
            bank_st[exp_bank] <= BANK_DRAINING;
            rx     <= '0;
            rline  <= '0;
            rlines <= (rem == '0) ? 5'd1 : (rem >= {13'b0, m_sz}) ? m_sz : rem[4:0];
         end
         pend <= issue;
         if (issue) begin
            if (rx == cw - XW'(1)) begin
               rx    <= '0;
               rline <= rline + 4'd1;
            end else begin
               rx <= rx + XW'(1);
            end
            p_x   <= rx;
            p_y   <= ry;
            p_sof <= (rx == '0) && (ry == '0);
            p_eol <= (rx == cw - XW'(1));
            p_eof <= (rx == cw - XW'(1)) && (ry == ch - XW'(1));
         end
         // Release is applied before a same-cycle completion so a bank
         // refilled in that cycle ends up FULL.
         if (release_b) begin
            bank_st[exp_bank] <= BANK_EMPTY;
            last_q[exp_bank]  <= 1'b0;
            if (last_q[exp_bank]) begin
               busy_q   <= 1'b0;
               exp_bank <= 1'b0;
            end else begin
               exp_bank <= !exp_bank;
            end
         end
         if (mark) begin
            bank_st[wbank] <= BANK_FULL;
            sy[wbank]      <= wsy;
            if (in_end) last_q[wbank] <= 1'b1;
         end
         if (pend) begin
            f_rgb[wp] <= ram_rd;
            f_x[wp]   <= p_x;
            f_y[wp]   <= p_y;
            f_flg[wp] <= {p_sof, p_eol, p_eof};
            wp        <= !wp;
         end
         if (pop) rp <= !rp;
         cnt <= cnt + {1'b0, pend} - {1'b0, pop};
      end
   end

   jpeg_strip_ram #(.DW(DW), .AW(AW)) u_ram (
      .clk (clk),
      .we  (ram_we),
      .wa  (wa),
      .wd  ({in_r, in_g, in_b}),
      .re  (issue),
      .ra  ({exp_bank, rline, rx[CW-1:0]}),
      .rd  (ram_rd)
   );

   assign out_valid = (cnt != 2'd0);
   assign out_r     = f_rgb[rp][DW-1 -: PIX_W];
   assign out_g     = f_rgb[rp][PIX_W +: PIX_W];
   assign out_b     = f_rgb[rp][0 +: PIX_W];
   assign out_x     = f_x[rp];
   assign out_y     = f_y[rp];
   assign out_sof   = f_flg[rp][2];
   assign out_eol   = f_flg[rp][1];
   assign out_eof   = f_flg[rp][0];
   assign busy      = busy_q;

endmodule
